// File: rtl/ram_dump_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_dump_streamer_pkg
// Description : Shared width helpers and FSM state encoding for the capture
//               RAM readback streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_dump_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Bits in one RAM burst word.
  function automatic int word_bits(input int no_of_digits, input int radix_bits,
                                   input int burst_index);
    return (no_of_digits + 1) * radix_bits * burst_index;
  endfunction

  function automatic int byte_count(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic int padded_bits(input int width);
    return 8 * byte_count(width);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dump_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_dump_streamer_if
// Description : Control, RAM read port and byte stream bundle of the streamer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_dump_streamer_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int WORD_WIDTH    = 165
);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [WORD_WIDTH-1:0]    ram_q;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_last;
  logic                     tx_ready;

  modport master (
    input  start, ram_q, tx_ready,
    output busy, done, ram_addr, tx_data, tx_valid, tx_last
  );

  modport slave (
    output start, ram_q, tx_ready,
    input  busy, done, ram_addr, tx_data, tx_valid, tx_last
  );

endinterface
`default_nettype wire

// File: rtl/ram_dump_streamer_word_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_serializer
// Description : Loads one RAM word and shifts it out LS byte first on a
//               registered valid/ready byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_serializer
  import ram_dump_streamer_pkg::*;
#(
  parameter int WORD_WIDTH = 165
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_load,
  input  wire logic [WORD_WIDTH-1:0] i_word,
  input  wire logic                  i_tx_ready,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  output logic                       o_tx_last,
  output logic                       o_last_accept
);

  localparam int c_BYTES = byte_count(WORD_WIDTH);
  localparam int c_PAD_W = padded_bits(WORD_WIDTH);
  localparam int c_IDX_W = idx_bits(c_BYTES);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BYTES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  logic [c_PAD_W-1:0] w_word_pad;
  logic [c_PAD_W-1:0] r_shift;
  logic [c_IDX_W-1:0] r_byte_idx;
  logic               r_valid;
  logic               r_last;
  logic               w_accept;

  generate
    if (c_PAD_W > WORD_WIDTH) begin : g_pad
      assign w_word_pad = {{(c_PAD_W - WORD_WIDTH){1'b0}}, i_word};
    end else begin : g_no_pad
      assign w_word_pad = i_word;
    end
  endgenerate

  assign w_accept = r_valid & i_tx_ready;

  // Data and last only move on load or handshake, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else if (i_load) begin
      r_shift    <= w_word_pad;
      r_byte_idx <= '0;
      r_valid    <= 1'b1;
      r_last     <= (c_BYTES == 1);
    end else if (w_accept) begin
      r_shift    <= r_shift >> 8;
      r_byte_idx <= r_byte_idx + c_IDX_ONE;
      r_valid    <= ~r_last;
      r_last     <= ((r_byte_idx + c_IDX_ONE) == c_LAST_IDX);
    end
  end

  assign o_tx_data     = r_shift[7:0];
  assign o_tx_valid    = r_valid;
  assign o_tx_last     = r_last;
  assign o_last_accept = w_accept & r_last;

endmodule
`default_nettype wire

// File: rtl/ram_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ram_dump_streamer
// Description : Walks the capture RAM from address 0 upward and streams every
//               word out as bytes; owns the RAM address bus while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dump_streamer
  import ram_dump_streamer_pkg::*;
#(
  parameter int no_of_digits     = 10,
  parameter int radix_bits       = 3,
  parameter int burst_index      = 5,
  parameter int address_width    = 14,
  parameter int max_ram_address  = 4096,
  parameter int ram_read_latency = 2
) (
  input wire logic          variable_clk_s,
  input wire logic          reset,
  ram_dump_streamer_if.master bus
);

  localparam int c_W      = word_bits(no_of_digits, radix_bits, burst_index);
  localparam int c_WAIT_W = idx_bits(ram_read_latency);
  localparam logic [c_WAIT_W-1:0]      c_WAIT_RELOAD = c_WAIT_W'(ram_read_latency - 1);
  localparam logic [c_WAIT_W-1:0]      c_WAIT_ONE    = c_WAIT_W'(1);
  localparam logic [address_width-1:0] c_LAST_ADDR   = address_width'(max_ram_address - 1);
  localparam logic [address_width-1:0] c_ADDR_ONE    = address_width'(1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [address_width-1:0] r_addr;
  logic [address_width-1:0] w_addr_nxt;
  logic [c_WAIT_W-1:0]      r_wait;
  logic [c_WAIT_W-1:0]      w_wait_nxt;
  logic                     r_busy;
  logic                     r_done;
  logic                     w_load;
  logic                     w_last_accept;

  always_ff @(posedge variable_clk_s) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wait  <= w_wait_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wait_nxt  = r_wait;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_WAIT;
          w_addr_nxt  = '0;
          w_wait_nxt  = c_WAIT_RELOAD;
        end
      end
      ST_WAIT: begin
        if (r_wait == '0) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_wait_nxt = r_wait - c_WAIT_ONE;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_last_accept) begin
          if (r_addr == c_LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_addr_nxt  = r_addr + c_ADDR_ONE;
            w_wait_nxt  = c_WAIT_RELOAD;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  word_byte_serializer #(
    .WORD_WIDTH (c_W)
  ) u_serializer (
    .clk           (variable_clk_s),
    .rst           (reset),
    .i_load        (w_load),
    .i_word        (bus.ram_q),
    .i_tx_ready    (bus.tx_ready),
    .o_tx_data     (bus.tx_data),
    .o_tx_valid    (bus.tx_valid),
    .o_tx_last     (bus.tx_last),
    .o_last_accept (w_last_accept)
  );

  assign bus.ram_addr = r_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dump_streamer
// Description : Scoreboard bench for ram_dump_streamer, 4-word RAM, read
//               latency 2 (main instance) and 1 (timing instance).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_dump_streamer;
  import ram_dump_streamer_pkg::*;

  localparam int c_W     = word_bits(10, 3, 5);
  localparam int c_AW    = 2;
  localparam int c_WORDS = 4;
  localparam int c_BYTES = 21;
  localparam int c_TOTAL = 84;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rdy_rand = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_acc1 = 0;
  exp_t sb[$];
  logic [c_W-1:0] mem [c_WORDS];
  logic [c_W-1:0] q2_stage;

  always #5 clk = ~clk;

  ram_dump_streamer_if #(.ADDRESS_WIDTH(c_AW), .WORD_WIDTH(c_W)) bus2 ();
  ram_dump_streamer_if #(.ADDRESS_WIDTH(c_AW), .WORD_WIDTH(c_W)) bus1 ();

  ram_dump_streamer #(
    .no_of_digits(10), .radix_bits(3), .burst_index(5), .address_width(c_AW),
    .max_ram_address(c_WORDS), .ram_read_latency(2)
  ) u_dut_l2 (
    .variable_clk_s(clk), .reset(reset), .bus(bus2)
  );

  ram_dump_streamer #(
    .no_of_digits(10), .radix_bits(3), .burst_index(5), .address_width(c_AW),
    .max_ram_address(c_WORDS), .ram_read_latency(1)
  ) u_dut_l1 (
    .variable_clk_s(clk), .reset(reset), .bus(bus1)
  );

  // Behavioral RAMs: two-stage read for the main instance, one stage for the other.
  always @(posedge clk) begin
    q2_stage   <= mem[bus2.ram_addr];
    bus2.ram_q <= q2_stage;
    bus1.ram_q <= mem[bus1.ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_dump();
    for (int w = 0; w < c_WORDS; w++) begin
      for (int b = 0; b < c_BYTES; b++) begin
        exp_t e;
        if (w == 0) e.data = (b == 0) ? 8'h01 : 8'h00;
        else        e.data = (b == c_BYTES - 1) ? 8'h1F : 8'hFF;
        e.last = (b == c_BYTES - 1);
        e.addr = 2'(w);
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    bus2.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus2.tx_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor for the main instance: pops on each handshake, checks stall stability.
  initial begin
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_stall;
    exp_t       e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(bus2.tx_valid), 32'd1);
          check("stall_data", 32'(bus2.tx_data), 32'(prev_data));
          check("stall_last", 32'(bus2.tx_last), 32'(prev_last));
        end
        if (bus2.tx_valid && bus2.tx_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", bus2.tx_data, $time);
          end else begin
            e = sb.pop_front();
            check("byte_data", 32'(bus2.tx_data), 32'(e.data));
            check("byte_last", 32'(bus2.tx_last), 32'(e.last));
            check("byte_addr", 32'(bus2.ram_addr), 32'(e.addr));
          end
          n_acc++;
        end
        prev_stall = bus2.tx_valid && !bus2.tx_ready;
        prev_data  = bus2.tx_data;
        prev_last  = bus2.tx_last;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && bus1.tx_valid && bus1.tx_ready) n_acc1++;
    end
  end

  task automatic run_dump(input bit timed, input int restart_at);
    int  base;
    int  done_seen;
    int  done_idx;
    int  fall_idx;
    bit  finished;
    base      = n_acc;
    done_seen = 0;
    done_idx  = -1;
    fall_idx  = -1;
    finished  = 1'b0;
    push_dump();
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    check("start_busy", 32'(bus2.busy), 32'd1);
    check("start_addr", 32'(bus2.ram_addr), 32'd0);
    // Iteration i observes the state right after edge k+i (k = start edge).
    for (int i = 0; i < 3000; i++) begin
      bus2.start = (i == restart_at);
      if (bus2.done) begin
        done_seen++;
        if (done_idx < 0) done_idx = i;
      end
      if (done_idx >= 0 && !bus2.busy) begin
        fall_idx = i;
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus2.start = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: got no done/busy drop, expected completion within 3000 cycles");
    end
    check("done_count", 32'(done_seen), 32'd1);
    check("busy_fall", 32'(fall_idx), 32'(done_idx + 1));
    if (timed) check("done_cycle", 32'(done_idx), 32'd96);
    repeat (2) @(negedge clk);
    check("byte_count", 32'(n_acc - base), 32'(c_TOTAL));
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base;
    int first_valid;
    int done_idx;
    bit reached;
    mem[0] = c_W'(1);
    for (int w = 1; w < c_WORDS; w++) mem[w] = '1;
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    bus1.tx_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(bus2.tx_valid), 32'd0);
    check("rst_busy", 32'(bus2.busy), 32'd0);
    check("rst_addr", 32'(bus2.ram_addr), 32'd0);
    check("rst_done", 32'(bus2.done), 32'd0);
    check("rst_data", 32'(bus2.tx_data), 32'd0);
    check("rst_last", 32'(bus2.tx_last), 32'd0);
    reset = 1'b0;

    run_dump(1'b1, -1);

    rdy_rand = 1'b1;
    run_dump(1'b0, -1);
    rdy_rand = 1'b0;

    run_dump(1'b0, 30);

    // Reset while word 2, byte 5 (stream byte 47) is on the bus.
    base = n_acc;
    reached = 1'b0;
    push_dump();
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (n_acc - base == 47) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!reached) begin
      total++;
      bad++;
      $display("FAIL reset_point_timeout: got %0d bytes, expected 47", n_acc - base);
    end
    check("mid_valid_before", 32'(bus2.tx_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus2.tx_valid), 32'd0);
    check("mid_rst_busy", 32'(bus2.busy), 32'd0);
    check("mid_rst_addr", 32'(bus2.ram_addr), 32'd0);
    check("mid_rst_last", 32'(bus2.tx_last), 32'd0);
    reset = 1'b0;
    sb.delete();
    run_dump(1'b0, -1);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus2.start = 1'b0;
    check("rs_busy", 32'(bus2.busy), 32'd0);
    check("rs_valid", 32'(bus2.tx_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("rs_busy_later", 32'(bus2.busy), 32'd0);
    check("rs_valid_later", 32'(bus2.tx_valid), 32'd0);

    // Latency-1 instance: first byte at k+2, 23 cycles per word, done at k+92.
    base = n_acc1;
    first_valid = -1;
    done_idx = -1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus1.tx_valid && first_valid < 0) first_valid = i;
      if (bus1.done) begin
        done_idx = i;
        break;
      end
      @(negedge clk);
    end
    check("l1_first_valid", 32'(first_valid), 32'd2);
    check("l1_done_cycle", 32'(done_idx), 32'd92);
    repeat (2) @(negedge clk);
    check("l1_byte_count", 32'(n_acc1 - base), 32'(c_TOTAL));
    check("l1_idle", 32'(bus1.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
